// File: rtl/cpu_out_fifo.sv
// cpu_out_fifo: captures every change of CPUOut into a small FIFO for a downstream consumer.
// Ports:
//    CLK      - single clock, all state updates on its rising edge
//    Reset    - synchronous active-low reset
//    CPUOut   - CPU output word being monitored (WIDTH bits)
//    OutData  - head-of-FIFO word, combinational read at the read pointer
//    OutValid - FIFO non-empty
//    OutReady - consumer accepts OutData when high
//    Count    - occupied entries (log2(DEPTH)+1 bits)
//    Full     - Count == DEPTH
//    Overflow - sticky flag, a capture was dropped because the FIFO was full
//    OutStamp - (CPU_OUT_TIMESTAMP_EN only) capture cycle stamp aligned with OutData
// Optional feature: define CPU_OUT_TIMESTAMP_EN to stamp each accepted word with a
// 16-bit free-running cycle counter.
module cpu_out_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                    CLK,
   input  logic                    Reset,
   input  logic [WIDTH-1:0]        CPUOut,
   output logic [WIDTH-1:0]        OutData,
   output logic                    OutValid,
   input  logic                    OutReady,
   output logic [$clog2(DEPTH):0]  Count,
   output logic                    Full,
   output logic                    Overflow
`ifdef CPU_OUT_TIMESTAMP_EN
   ,
   output logic [15:0]             OutStamp
`endif
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp;
   logic [AW-1:0]    r_rp;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_last;
   logic             r_ovf;
   logic             w_push;
   logic             w_pop;
   logic             w_wr;
   // Reset gates both push and pop so nothing moves during a reset cycle.
   always_comb begin
      w_push = Reset && (CPUOut != r_last);
      w_pop  = Reset && OutValid && OutReady;
      // A full FIFO still accepts a word when the head leaves in the same cycle.
      w_wr   = w_push && (!Full || w_pop);
   end
   assign OutValid = r_count != '0;
   assign Full     = r_count == (AW+1)'(DEPTH);
   assign Count    = r_count;
   assign Overflow = r_ovf;
   assign OutData  = r_mem[r_rp];
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_last  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_wr) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_count <= (w_wr && !w_pop) ? r_count + 1'b1 :
                    (w_pop && !w_wr) ? r_count - 1'b1 : r_count;
         // Last tracks every detected change, even a dropped one, so a held value is not retried.
         if (w_push) r_last <= CPUOut;
         if (w_push && !w_wr) r_ovf <= 1'b1;
      end
   end
   // Storage is not reset so it can map onto plain RAM.
   always_ff @(posedge CLK) begin
      if (w_wr) r_mem[r_wp] <= CPUOut;
   end
`ifdef CPU_OUT_TIMESTAMP_EN
   logic [15:0] r_stamp;
   logic [15:0] r_smem [DEPTH];
   always_ff @(posedge CLK) begin
      r_stamp <= !Reset ? 16'd0 : r_stamp + 16'd1;
   end
   always_ff @(posedge CLK) begin
      if (w_wr) r_smem[r_wp] <= r_stamp;
   end
   assign OutStamp = r_smem[r_rp];
`endif
endmodule

// File: tb/tb_cpu_out_fifo.sv
// tb_cpu_out_fifo: self-checking bench for cpu_out_fifo against a queue-based reference model.
module tb_cpu_out_fifo;
   localparam int W = 32;
   localparam int D = 8;
   logic         CLK = 1'b0;
   logic         Reset = 1'b0;
   logic [W-1:0] CPUOut = '0;
   logic         OutReady = 1'b0;
   logic [W-1:0] OutData;
   logic         OutValid;
   logic [3:0]   Count;
   logic         Full;
   logic         Overflow;
`ifdef CPU_OUT_TIMESTAMP_EN
   logic [15:0]  OutStamp;
   logic [15:0]  sq[$];
   logic [15:0]  m_stamp;
`endif
   cpu_out_fifo #(.WIDTH(W), .DEPTH(D)) dut (
      .CLK(CLK), .Reset(Reset), .CPUOut(CPUOut), .OutData(OutData), .OutValid(OutValid),
      .OutReady(OutReady), .Count(Count), .Full(Full), .Overflow(Overflow)
`ifdef CPU_OUT_TIMESTAMP_EN
      , .OutStamp(OutStamp)
`endif
   );
   always #5 CLK = ~CLK;
   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] q[$];
   logic [W-1:0] m_last;
   bit           m_ovf;
   typedef struct {
      logic         rst;
      logic [W-1:0] cpu;
      logic         rdy;
      int           cnt;
      logic         v;
      logic [W-1:0] data;
   } vec_t;
   vec_t tbl[12];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // Drive one cycle, advance the reference model, then compare all outputs 1 time unit after the edge.
   task automatic apply(input logic rst, input logic [W-1:0] cpu, input logic rdy);
      bit push, pop, acc;
      Reset = rst;
      CPUOut = cpu;
      OutReady = rdy;
      @(posedge CLK);
      if (!rst) begin
         q.delete();
         m_last = '0;
         m_ovf = 0;
`ifdef CPU_OUT_TIMESTAMP_EN
         sq.delete();
         m_stamp = 16'd0;
`endif
      end else begin
         push = cpu != m_last;
         pop = q.size() > 0 && rdy;
         acc = push && (q.size() < D || pop);
         if (pop) begin
            void'(q.pop_front());
`ifdef CPU_OUT_TIMESTAMP_EN
            void'(sq.pop_front());
`endif
         end
         if (acc) begin
            q.push_back(cpu);
`ifdef CPU_OUT_TIMESTAMP_EN
            sq.push_back(m_stamp);
`endif
         end
         if (push && !acc) m_ovf = 1;
         if (push) m_last = cpu;
`ifdef CPU_OUT_TIMESTAMP_EN
         m_stamp = m_stamp + 16'd1;
`endif
      end
      #1;
      chk("model_valid", OutValid, q.size() != 0);
      chk("model_count", Count, q.size());
      chk("model_full", Full, q.size() == D);
      chk("model_ovf", Overflow, m_ovf);
      if (q.size() != 0) begin
         chk("model_data", OutData, q[0]);
`ifdef CPU_OUT_TIMESTAMP_EN
         chk("model_stamp", OutStamp, sq[0]);
`endif
      end
   endtask
   function automatic vec_t mk(logic rst, logic [W-1:0] cpu, logic rdy, int cnt, logic v, logic [W-1:0] data);
      vec_t t;
      t.rst = rst; t.cpu = cpu; t.rdy = rdy; t.cnt = cnt; t.v = v; t.data = data;
      return t;
   endfunction
   initial begin
      logic [W-1:0] exp_d;
      tbl[0]  = mk(0, 'h00, 0, 0, 0, 'h00);
      tbl[1]  = mk(1, 'h00, 0, 0, 0, 'h00);
      tbl[2]  = mk(1, 'h00, 0, 0, 0, 'h00);
      tbl[3]  = mk(1, 'h00, 1, 0, 0, 'h00);
      tbl[4]  = mk(1, 'h00, 0, 0, 0, 'h00);
      tbl[5]  = mk(1, 'h00, 0, 0, 0, 'h00);
      tbl[6]  = mk(1, 'h0F, 0, 1, 1, 'h0F);
      tbl[7]  = mk(1, 'h1E, 0, 2, 1, 'h0F);
      tbl[8]  = mk(1, 'h2D, 0, 3, 1, 'h0F);
      tbl[9]  = mk(1, 'h2D, 1, 2, 1, 'h1E);
      tbl[10] = mk(1, 'h2D, 1, 1, 1, 'h2D);
      tbl[11] = mk(1, 'h2D, 1, 0, 0, 'h00);
      for (int i = 0; i < 12; i++) begin
         apply(tbl[i].rst, tbl[i].cpu, tbl[i].rdy);
         chk($sformatf("tbl%0d_count", i), Count, tbl[i].cnt);
         chk($sformatf("tbl%0d_valid", i), OutValid, tbl[i].v);
         chk($sformatf("tbl%0d_full", i), Full, 1'b0);
         chk($sformatf("tbl%0d_ovf", i), Overflow, 1'b0);
         if (tbl[i].v) chk($sformatf("tbl%0d_data", i), OutData, tbl[i].data);
      end
      for (int i = 0; i < 9; i++) begin
         apply(1, 'h100 + i, 0);
         if (i == 7) begin
            chk("fill8_count", Count, 8);
            chk("fill8_full", Full, 1);
            chk("fill8_ovf", Overflow, 0);
         end
      end
      chk("ovfl_count", Count, 8);
      chk("ovfl_full", Full, 1);
      chk("ovfl_ovf", Overflow, 1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("ovfl_drain%0d", i), OutData, 'h100 + i);
         apply(1, 'h108, 1);
      end
      chk("ovfl_empty", OutValid, 0);
      chk("ovfl_sticky", Overflow, 1);
      apply(0, 'h0, 0);
      for (int i = 0; i < 8; i++) apply(1, 'h200 + i, 0);
      chk("fullpop_pre_full", Full, 1);
      apply(1, 'h2FF, 1);
      chk("fullpop_count", Count, 8);
      chk("fullpop_ovf", Overflow, 0);
      for (int i = 0; i < 8; i++) begin
         exp_d = (i < 7) ? W'('h201 + i) : W'('h2FF);
         chk($sformatf("fullpop_drain%0d", i), OutData, exp_d);
         apply(1, 'h2FF, 1);
      end
      chk("fullpop_empty", OutValid, 0);
      for (int i = 0; i < 5; i++) apply(1, 'h300 + i, 0);
      chk("rst5_pre_count", Count, 5);
      apply(0, 'h304, 1);
      chk("rst5_count", Count, 0);
      chk("rst5_valid", OutValid, 0);
      chk("rst5_ovf", Overflow, 0);
      chk("rst5_full", Full, 0);
      apply(1, 'h304, 0);
      chk("first_cap_count", Count, 1);
      chk("first_cap_data", OutData, 'h304);
      apply(0, 'h0, 0);
      apply(1, 'h0, 0);
      chk("zero_nocap", Count, 0);
`ifdef CPU_OUT_TIMESTAMP_EN
      begin
         logic [15:0] s0;
         apply(0, 'h0, 0);
         for (int i = 0; i < 3; i++) apply(1, 'h0, 0);
         apply(1, 'hA, 0);
         for (int i = 0; i < 6; i++) apply(1, 'hA, 0);
         apply(1, 'hB, 0);
         chk("stamp_first", OutStamp, 3);
         s0 = OutStamp;
         apply(1, 'hB, 1);
         chk("stamp_second", OutStamp, 10);
         chk("stamp_diff", OutStamp - s0, 7);
      end
`endif
      apply(0, 'h0, 0);
      for (int i = 0; i < 3000; i++)
         apply($urandom_range(0, 99) != 0, W'($urandom_range(0, 15)), $urandom_range(0, 9) < 4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
